// File: rtl/rc4_sram_sequencer.sv
// rc4_sram_sequencer -- runs the three RC4 phases (init, key schedule,
// decrypt) in order and owns the single-port S-RAM. Each phase engine is
// started with a one-cycle pulse. The sequencer waits for that engine's level
// finish, then hands the RAM port to the next phase. A zero-latency mux
// routes the owning phase's address, data and wren to the RAM.
//
// Optional feature: define SEQ_WATCHDOG_EN to build a per-phase watchdog.
// A phase still in ARM/RUN after WDOG_CYCLES cycles sends the FSM to ERROR.
// Without the macro, error is tied low and ERROR cannot be reached.
module rc4_sram_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter bit AUTO_START  = 1'b1,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  output logic [2:0]          ph_start,
  input  logic [2:0]          ph_finish,
  input  logic [3*ADDR_W-1:0] ph_addr,
  input  logic [3*DATA_W-1:0] ph_data,
  input  logic [2:0]          ph_wren,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_data,
  output logic                s_wren,
  output logic [1:0]          phase,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_ARM, ST_RUN, ST_DONE, ST_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  p_q, p_d;
  logic        first_q;
  logic [2:0]  ph_start_q, ph_start_d;
  logic        wdog_hit;

  // Four-entry views so the 2-bit phase index never selects out of range.
  logic [ADDR_W-1:0] addr_sl [4];
  logic [DATA_W-1:0] data_sl [4];
  logic [3:0]        wren_ext;
  logic [3:0]        fin_ext;
  logic              fin_cur;

  // Slice the flattened per-phase buses; entry 3 is an idle all-zero source.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      addr_sl[g] = ph_addr[g*ADDR_W +: ADDR_W];
      data_sl[g] = ph_data[g*DATA_W +: DATA_W];
    end
    addr_sl[3] = '0;
    data_sl[3] = '0;
  end

  assign wren_ext = {1'b0, ph_wren};
  assign fin_ext  = {1'b0, ph_finish};
  assign fin_cur  = fin_ext[p_q];

`ifdef SEQ_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] wdog_q, wdog_d;

  // Watchdog counts ARM/RUN cycles since the current phase was started.
  always_comb begin
    wdog_d = wdog_q;
    if (state_d == ST_START)
      wdog_d = '0;
    else if (state_q == ST_ARM || state_q == ST_RUN)
      wdog_d = wdog_q + 16'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end

  assign wdog_hit = (state_q == ST_ARM || state_q == ST_RUN) && (wdog_q == WDOG_LAST);
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state logic: phase sequencing, stale-finish discard, restart on go.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (go || (AUTO_START && first_q)) begin
          state_d = ST_START;
          p_d     = 2'd0;
        end
      end
      ST_START: state_d = ST_ARM;
      ST_ARM: begin
        if (wdog_hit)      state_d = ST_ERROR;
        else if (!fin_cur) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wdog_hit) begin
          state_d = ST_ERROR;
        end else if (fin_cur) begin
          if (p_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_START;
            p_d     = p_q + 2'd1;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (go) begin
          state_d = ST_START;
          p_d     = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ph_start_d = (state_d == ST_START) ? (3'b001 << p_d) : 3'b000;
  end

  // State register; the start pulse is registered so it lines up with START.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      p_q        <= 2'd0;
      first_q    <= 1'b1;
      ph_start_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      first_q    <= 1'b0;
      ph_start_q <= ph_start_d;
    end
  end

  // Outputs and RAM port mux, decoded from the registered state and phase.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    phase     = 2'd3;
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    case (state_q)
      ST_START, ST_ARM, ST_RUN: begin
        busy      = 1'b1;
        phase     = p_q;
        s_address = addr_sl[p_q];
        s_data    = data_sl[p_q];
        s_wren    = wren_ext[p_q];
      end
      ST_DONE: done = 1'b1;
`ifdef SEQ_WATCHDOG_EN
      ST_ERROR: error = 1'b1;
`endif
      default: ;
    endcase
  end

  assign ph_start = ph_start_q;

endmodule
